// File: rtl/rgb_led_driver_pkg.sv
// rgb_pkg: shared colour type and named colour constants
// for the RGB LED driver and its stability filter.
package rgb_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_OFF   = 3'b000;
  localparam rgb_t RGB_RED   = 3'b100;
  localparam rgb_t RGB_GREEN = 3'b010;
  localparam rgb_t RGB_BLUE  = 3'b001;

endpackage

// File: rtl/rgb_led_driver_if.sv
// rgb_led_driver_if: comparator levels, PWM controls and LED
// pins. slave = driver side, master = the block feeding it.
interface rgb_led_driver_if #(
  parameter int CNT_W = 8
);
  import rgb_pkg::*;

  logic             red;
  logic             green;
  logic             blue;
  logic             en;
  logic [CNT_W-1:0] duty;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic [2:0]       colour_o;
  logic             changed;

  modport master (
    output red, green, blue, en, duty,
    input  led_r, led_g, led_b, colour_o, changed
  );

  modport slave (
    input  red, green, blue, en, duty,
    output led_r, led_g, led_b, colour_o, changed
  );

endinterface

// File: rtl/rgb_led_driver_stable_filter.sv
// rgb_stable_filter: commits a colour once it has been sampled
// STABLE_CYCLES times in a row. Ports: clk, rst, rgb_i in;
// colour_o (committed), colour_nxt_o (next committed), changed_o.
module rgb_stable_filter
  import rgb_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  rgb_t rgb_i,
  output rgb_t colour_o,
  output rgb_t colour_nxt_o,
  output logic changed_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] TH  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  rgb_t          in_q, in_d;
  rgb_t          cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rgb_t          colour_q, colour_d;
  logic          changed_q, changed_d;
  logic          commit;

  always_comb begin
    in_d      = rgb_i;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    commit    = (in_q == cand_q) && (cnt_q >= TH)
              && (cand_q != colour_q);
    if (in_q != cand_q) begin
      cand_d = in_q;
      cnt_d  = ONE;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + ONE;
    end
    if (commit) colour_d = cand_q;
    changed_d = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= RGB_OFF;
      cand_q    <= RGB_OFF;
      cnt_q     <= '0;
      colour_q  <= RGB_OFF;
      changed_q <= 1'b0;
    end else begin
      in_q      <= in_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      colour_q  <= colour_d;
      changed_q <= changed_d;
    end
  end

  assign colour_o     = colour_q;
  assign colour_nxt_o = colour_d;
  assign changed_o    = changed_q;

endmodule

// File: rtl/rgb_led_driver.sv
// rgb_led_driver: filtered colour drives RGB pins with PWM;
// colour/duty latch only at period boundaries. Ports: clk,
// rst, bus (slave: levels, en, duty in; led_*, colour_o, changed).
module rgb_led_driver
  import rgb_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  rgb_led_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  rgb_t             in_rgb;
  rgb_t             colour, colour_nxt;
  logic             changed;

  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  rgb_t             colour_pwm_q, colour_pwm_d;
  rgb_t             led_q, led_d;
  logic             en_q;
  logic             run, bound;

  assign in_rgb = '{r: bus.red, g: bus.green, b: bus.blue};

  rgb_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .rgb_i       (in_rgb),
    .colour_o    (colour),
    .colour_nxt_o(colour_nxt),
    .changed_o   (changed)
  );

  // The first enabled edge shows position 0, so a period
  // starts cleanly on enable rise.
  always_comb begin
    run          = bus.en & en_q;
    bound        = ~run | (pwm_cnt_q == '1);
    pwm_cnt_d    = run ? pwm_cnt_q + ONE : '0;
    duty_d       = bound ? bus.duty : duty_q;
    colour_pwm_d = bound ? colour_nxt : colour_pwm_q;
    led_d        = RGB_OFF;
    if (bus.en && (pwm_cnt_d < duty_d)) led_d = colour_pwm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      colour_pwm_q <= RGB_OFF;
      led_q        <= RGB_OFF;
      en_q         <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      colour_pwm_q <= colour_pwm_d;
      led_q        <= led_d;
      en_q         <= bus.en;
    end
  end

  assign bus.led_r    = led_q.r;
  assign bus.led_g    = led_q.g;
  assign bus.led_b    = led_q.b;
  assign bus.colour_o = colour;
  assign bus.changed  = changed;

endmodule

// File: tb/tb_rgb_led_driver.sv
// tb_rgb_led_driver: directed + random stimulus, reference
// model pushes expectations, monitor pops and compares.
module tb_rgb_led_driver;
  import rgb_pkg::*;

  localparam int CNT_W  = 4;
  localparam int STABLE = 4;
  localparam int PER    = 16;

  typedef struct packed {
    logic [2:0] led;
    logic [2:0] col;
    logic       chg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_led_driver_if #(.CNT_W(CNT_W)) bus ();

  rgb_led_driver #(
    .CNT_W        (CNT_W),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;

  // reference model state
  logic [2:0] hist[$];
  logic [2:0] m_col;
  logic [2:0] m_pcol;
  logic       m_prev_en;
  int         m_p;
  int         m_duty;

  // One clock of stimulus; model predicts outputs after the edge.
  task automatic step(input logic r, input logic [2:0] c,
                      input logic e, input int d);
    exp_t x;
    logic chg;
    logic [CNT_W-1:0] dv;
    logic stable;
    @(negedge clk);
    dv = d[CNT_W-1:0];
    rst = r;
    bus.red = c[2];
    bus.green = c[1];
    bus.blue = c[0];
    bus.en = e;
    bus.duty = dv;
    x = '0;
    if (r) begin
      hist = {3'b000, 3'b000, 3'b000, 3'b000};
      m_col = 3'b000;
      m_pcol = 3'b000;
      m_prev_en = 1'b0;
      m_p = 0;
      m_duty = 0;
    end else begin
      chg = 1'b0;
      stable = 1'b1;
      for (int i = 1; i < STABLE; i++)
        if (hist[i] != hist[0]) stable = 1'b0;
      if (stable && hist[0] != m_col) begin
        m_col = hist[0];
        chg = 1'b1;
      end
      void'(hist.pop_front());
      hist.push_back(c);
      if (!e || !m_prev_en || m_p == PER - 1) begin
        m_p = 0;
        m_duty = int'(dv);
        m_pcol = m_col;
      end else begin
        m_p = m_p + 1;
      end
      m_prev_en = e;
      x.led = (e && m_p < m_duty) ? m_pcol : 3'b000;
      x.col = m_col;
      x.chg = chg;
    end
    sb.push_back(x);
  endtask

  initial begin
    exp_t x;
    logic [2:0] got;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        got = {bus.led_r, bus.led_g, bus.led_b};
        if (got !== x.led || bus.colour_o !== x.col
            || bus.changed !== x.chg) begin
          miscompares++;
          $display("FAIL out@%0d got led=%b col=%b chg=%b exp led=%b col=%b chg=%b",
                   cyc, got, bus.colour_o, bus.changed,
                   x.led, x.col, x.chg);
        end
      end
    end
  end

  initial begin
    logic [2:0] c;
    logic e;
    int d;
    rst = 1'b1;
    bus.red = 1'b0;
    bus.green = 1'b0;
    bus.blue = 1'b0;
    bus.en = 1'b0;
    bus.duty = '0;
    // reset with all inputs active
    repeat (2) step(1'b1, 3'b111, 1'b1, 15);
    step(1'b0, 3'b111, 1'b1, 15);
    step(1'b1, 3'b000, 1'b1, 8);
    // commit red, duty 8
    repeat (60) step(1'b0, RGB_RED, 1'b1, 8);
    // short green glitch
    repeat (3) step(1'b0, RGB_GREEN, 1'b1, 8);
    repeat (40) step(1'b0, RGB_RED, 1'b1, 8);
    // duty boundaries
    repeat (40) step(1'b0, RGB_RED, 1'b1, 0);
    repeat (40) step(1'b0, RGB_RED, 1'b1, 15);
    repeat (20) step(1'b0, RGB_RED, 1'b1, 4);
    for (int i = 0; i < 40 && m_p != 2; i++)
      step(1'b0, RGB_RED, 1'b1, 4);
    repeat (40) step(1'b0, RGB_RED, 1'b1, 12);
    // enable low, then rise with blue at duty 3
    repeat (20) step(1'b0, RGB_BLUE, 1'b0, 0);
    repeat (40) step(1'b0, RGB_BLUE, 1'b1, 3);
    // reset mid-period while red is lit
    repeat (24) step(1'b0, RGB_RED, 1'b1, 8);
    for (int i = 0; i < 40 && m_p != 6; i++)
      step(1'b0, RGB_RED, 1'b1, 8);
    step(1'b1, RGB_GREEN, 1'b1, 8);
    repeat (30) step(1'b0, RGB_GREEN, 1'b1, 8);
    // random traffic
    c = RGB_GREEN;
    e = 1'b1;
    d = 8;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(5) == 0) c = 3'($urandom_range(7));
      if ($urandom_range(19) == 0) e = ~e;
      if ($urandom_range(9) == 0) d = $urandom_range(15);
      step($urandom_range(299) == 0, c, e, d);
    end
    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
